data_mem_mmio: RTL
==================

# data_mem_mmio

Data-memory block on the CPU's external memory port: a 48-word RAM plus a memory-mapped I/O window, serving the pipelined CPU's stage-4 read/write pins. Reads are combinational, so the CPU captures data in the same cycle it presents the address. Writes commit at the clock edge. The I/O window provides an LED register, a free-running cycle counter and a byte-wide TX FIFO drained through a valid/ready handshake.

## Interface
- TX_FIFO_DEPTH, 8, TX FIFO entries; a power of two in the range 2–16.
- clk  in  1  system clock; all state is updated on its rising edge.
- rst  in  1  synchronous, active-high reset.
- clk_enable  in  1  global stall; when low, no state changes at all.
- i_mem_read_address  in  8  byte address of the read; bits [1:0] are ignored.
- i_mem_write_address  in  8  byte address of the write; bits [1:0] are ignored.
- i_mem_write_data  in  32  write word.
- i_mem_write_enable  in  1  write strobe.
- o_mem_read_data  out  32  combinational read word.
- o_leds  out  8  LED register.
- o_tx_data  out  8  FIFO head byte.
- o_tx_valid  out  1  FIFO non-empty.
- i_tx_ready  in  1  consumer accepts the head byte.

## Operation
- Address map, word-aligned:
  - 0x00–0xBF: RAM, 48 words, index = addr[7:2].
  - 0xC0 LEDS: RW; bits [7:0] drive o_leds.
  - 0xC4 CYCLES: RO; any write clears it.
  - 0xC8 TXDATA: WO; a write pushes data[7:0]; reads return 0.
  - 0xCC TXSTAT: RO except bit 7.
    - bit 0 = full, bit 1 = empty, bits [6:2] = count.
    - bit 7 = sticky overflow; any write to TXSTAT clears it.
  - 0xD0–0xFF: reads return 0; writes are ignored.
- Unused upper bits of the LEDS, TXSTAT and TXDATA read words return 0.
- RAM is not reset; it initialises to zero at time 0.
- CYCLES increments by 1 on every edge where clk_enable=1 and rst=0. It wraps from 0xFFFFFFFF to 0.
- TX push occurs on a TXDATA write.
  - If the FIFO is full and no pop happens that cycle, the byte is dropped and overflow is set.
- TX pop occurs when o_tx_valid && i_tx_ready && clk_enable.
- o_tx_data is the head entry and must hold stable while o_tx_valid=1 and no pop occurs.

## Timing
- Read latency is 0 cycles: o_mem_read_data is a pure function of i_mem_read_address and current state.
- Write latency is 1 edge: a read of the same address in the following cycle returns the new value.
- On a same-cycle read and write to the same address, the read returns the old value.
- A push is visible as o_tx_valid=1 at the next edge. An empty FIFO never bypasses a byte to o_tx_data in the same cycle.
- Push and pop in the same cycle: count is unchanged, and the push is accepted even when the FIFO is full.
- A CYCLES write and an increment in the same cycle give a result of 0; counting resumes at the next edge.
- Pointers wrap modulo TX_FIFO_DEPTH. Count runs from 0 to TX_FIFO_DEPTH.
- Every state-changing edge requires clk_enable=1, with one exception: rst=1 resets regardless of clk_enable.
- Reset values:
  - o_leds=0, CYCLES=0, FIFO empty (o_tx_valid=0), overflow=0.
  - o_tx_data=0 while the FIFO is empty.
  - o_mem_read_data follows the address (combinational).
- Reset mid-transfer discards all FIFO contents. A write in the reset cycle is ignored for MMIO; a RAM write in that cycle still commits.

## Structure
- constants.vh gains:
  - the MMIO base and the LEDS, CYCLES, TXDATA and TXSTAT offsets;
  - the TXSTAT bit positions;
  - RAM_WORDS = 48.
  - It reuses the existing MEM_ADDR_WIDTH and MEM_WORD_WIDTH.
- Sub-module tx_fifo:
  - parameterised by depth;
  - push/pop interface with full, empty and count outputs, plus a head-data output;
  - pop-before-push semantics as defined above.
- The top level holds the RAM array, the address decode, the LED register, the cycle counter and the overflow flag.

## Test plan
- Write 0xDEADBEEF to 0x10, then read 0x10 on the next cycle -> 0xDEADBEEF. A read of 0x13 returns the same word. A read of 0xD4 returns 0.
- Write 0x1A5 to 0xC0 -> o_leds=0xA5 one edge later. Assert rst -> o_leds=0 and CYCLES reads 0.
- After reset, hold clk_enable low for 3 cycles, then high for 5 -> CYCLES=5. Write CYCLES -> the next read is 0 and the read after that is 1.
- With i_tx_ready=0, push 9 bytes (0x01..0x09), DEPTH=8:
  - TXSTAT=0x1+(8<<2)+0x80 = 0xA1.
  - Raise ready -> bytes 0x01..0x08 appear in order, one per cycle, and byte 9 is absent.
- Fill the FIFO, then push 0x55 while popping in the same cycle -> count stays 8, overflow stays 0, and 0x55 emerges last.
- Push 3 bytes, assert rst with ready=1 -> o_tx_valid=0 the next cycle and TXSTAT=0x02.

Source files
------------

// File: rtl/data_mem_mmio_pkg.sv
// data_mem_mmio_pkg: address map, TXSTAT bit positions, region type and address decoder
package data_mem_mmio_pkg;
    localparam int MEM_ADDR_WIDTH = 8;
    localparam int MEM_WORD_WIDTH = 32;
    localparam int RAM_WORDS = 48;
    localparam logic [MEM_ADDR_WIDTH-1:0] MMIO_BASE = 8'hC0;
    localparam logic [MEM_ADDR_WIDTH-1:0] LEDS_OFF = 8'h00;
    localparam logic [MEM_ADDR_WIDTH-1:0] CYCLES_OFF = 8'h04;
    localparam logic [MEM_ADDR_WIDTH-1:0] TXDATA_OFF = 8'h08;
    localparam logic [MEM_ADDR_WIDTH-1:0] TXSTAT_OFF = 8'h0C;
    localparam int TXSTAT_FULL = 0;
    localparam int TXSTAT_EMPTY = 1;
    localparam int TXSTAT_COUNT = 2;
    localparam int TXSTAT_OVF = 7;

    typedef enum logic [2:0] {REG_RAM, REG_LEDS, REG_CYCLES, REG_TXDATA, REG_TXSTAT, REG_NONE} region_t;

    function automatic region_t decode(input logic [MEM_ADDR_WIDTH-1:0] a);
        logic [MEM_ADDR_WIDTH-1:0] w;
        w = {a[MEM_ADDR_WIDTH-1:2], 2'b00};
        return w < MMIO_BASE ? REG_RAM :
               w == MMIO_BASE + LEDS_OFF ? REG_LEDS :
               w == MMIO_BASE + CYCLES_OFF ? REG_CYCLES :
               w == MMIO_BASE + TXDATA_OFF ? REG_TXDATA :
               w == MMIO_BASE + TXSTAT_OFF ? REG_TXSTAT : REG_NONE;
    endfunction
endpackage

// File: rtl/data_mem_mmio_tx_fifo.sv
// tx_fifo: byte FIFO (clk, rst, push, pop, din -> dout head, full, empty, count), pop-before-push
module tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [7:0]             din,
    output logic [7:0]             dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty = count_q == '0;
    assign full = count_q == CW'(DEPTH);
    assign count = count_q;
    assign dout = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign do_pop = pop && !empty;
    // a full FIFO still takes a byte when the head leaves on the same edge
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk)
        if (do_push) mem_q[wr_ptr_q] <= din;
endmodule

// File: rtl/data_mem_mmio.sv
// data_mem_mmio: 48-word RAM plus LEDS/CYCLES/TXDATA/TXSTAT MMIO on the CPU data port, TX byte stream out
module data_mem_mmio
    import data_mem_mmio_pkg::*;
#(
    parameter int TX_FIFO_DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk_enable,
    input  logic [MEM_ADDR_WIDTH-1:0] i_mem_read_address,
    input  logic [MEM_ADDR_WIDTH-1:0] i_mem_write_address,
    input  logic [MEM_WORD_WIDTH-1:0] i_mem_write_data,
    input  logic                      i_mem_write_enable,
    output logic [MEM_WORD_WIDTH-1:0] o_mem_read_data,
    output logic [7:0]                o_leds,
    output logic [7:0]                o_tx_data,
    output logic                      o_tx_valid,
    input  logic                      i_tx_ready
);
    logic [MEM_WORD_WIDTH-1:0] ram_q [RAM_WORDS] = '{default: '0};
    logic [7:0]  leds_q, leds_d;
    logic [31:0] cycles_q, cycles_d;
    logic        ovf_q, ovf_d;
    logic [31:0] stat;
    logic        wr_en, tx_push, tx_pop, tx_full, tx_empty;
    logic [$clog2(TX_FIFO_DEPTH):0] tx_count;
    region_t     rd_region, wr_region;

    assign rd_region = decode(i_mem_read_address);
    assign wr_region = decode(i_mem_write_address);
    assign wr_en = clk_enable && i_mem_write_enable;
    assign tx_push = wr_en && wr_region == REG_TXDATA;
    assign tx_pop = o_tx_valid && i_tx_ready && clk_enable;
    assign o_tx_valid = !tx_empty;
    assign o_leds = leds_q;

    tx_fifo #(.DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (i_mem_write_data[7:0]),
        .dout  (o_tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    always_comb begin
        stat = '0;
        stat[TXSTAT_FULL] = tx_full;
        stat[TXSTAT_EMPTY] = tx_empty;
        stat[TXSTAT_COUNT +: 5] = 5'(tx_count);
        stat[TXSTAT_OVF] = ovf_q;
        case (rd_region)
            REG_RAM:    o_mem_read_data = ram_q[i_mem_read_address[7:2]];
            REG_LEDS:   o_mem_read_data = {24'h0, leds_q};
            REG_CYCLES: o_mem_read_data = cycles_q;
            REG_TXSTAT: o_mem_read_data = stat;
            default:    o_mem_read_data = '0;
        endcase
    end

    always_comb begin
        leds_d = wr_en && wr_region == REG_LEDS ? i_mem_write_data[7:0] : leds_q;
        // a clearing write beats the increment on the same edge
        cycles_d = !clk_enable ? cycles_q : wr_en && wr_region == REG_CYCLES ? '0 : cycles_q + 32'd1;
        ovf_d = wr_en && wr_region == REG_TXSTAT ? 1'b0 : tx_push && tx_full && !tx_pop ? 1'b1 : ovf_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            leds_q <= '0;
            cycles_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            leds_q <= leds_d;
            cycles_q <= cycles_d;
            ovf_q <= ovf_d;
        end
    end

    // RAM writes ignore rst so a store issued during reset still lands
    always_ff @(posedge clk)
        if (wr_en && wr_region == REG_RAM) ram_q[i_mem_write_address[7:2]] <= i_mem_write_data;
endmodule
